// File: rtl/pacman_pkg.sv
// Shared constants for the pellet-eating logic: tile codes, score values,
// default maze geometry and the request FSM encoding.
package pacman_pkg;

    localparam int MAP_W        = 28;
    localparam int MAP_H        = 31;

    localparam int TILE_EMPTY   = 0;
    localparam int TILE_WALL    = 1;
    localparam int TILE_PELLET  = 2;
    localparam int TILE_POWER   = 3;

    localparam int PELLET_SCORE = 10;
    localparam int POWER_SCORE  = 50;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_CHK
    } state_e;

endpackage

// File: rtl/pellet_eater.sv
// Consumes the tile Pacman steps onto: read-check-clear via map BRAM port B,
// with saturating score, remaining-pellet count and level-clear flag.
module pellet_eater #(
    parameter int   MAP_W        = pacman_pkg::MAP_W,
    parameter int   MAP_H        = pacman_pkg::MAP_H,
    parameter int   DATA_WIDTH   = 4,
    parameter int   INIT_PELLETS = 244,
    localparam int  ADDR_W       = $clog2(MAP_W*MAP_H)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [4:0]            tile_x,
    input  logic [4:0]            tile_y,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic                  bram_we,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [15:0]           score,
    output logic [9:0]            pellets_left,
    output logic                  ate_pulse,
    output logic                  power_pulse,
    output logic                  level_clear
);
    import pacman_pkg::*;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         score_q, score_d;
    logic [9:0]          pel_q, pel_d;
    logic                lc_q, lc_d;
    logic                ate_q, ate_d;
    logic                pow_q, pow_d;

    logic                in_range;
    logic                is_pellet;
    logic                is_power;
    logic [15:0]         add_val;
    logic [16:0]         sum;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pel_d     = pel_q;
        lc_d      = lc_q;
        ate_d     = 1'b0;
        pow_d     = 1'b0;
        bram_we   = 1'b0;
        add_val   = 16'd0;

        in_range  = (int'(tile_x) < MAP_W) && (int'(tile_y) < MAP_H);
        is_pellet = (bram_dout == DATA_WIDTH'(TILE_PELLET));
        is_power  = (bram_dout == DATA_WIDTH'(TILE_POWER));

        case (state_q)
            ST_IDLE: begin
                // Off-map requests are accepted and dropped without touching the BRAM
                if (req_valid && in_range) begin
                    addr_d  = ADDR_W'(int'(tile_y) * MAP_W + int'(tile_x));
                    state_d = ST_RD;
                end
            end
            ST_RD:   state_d = ST_CHK;
            ST_CHK: begin
                state_d = ST_IDLE;
                if (is_pellet || is_power) begin
                    bram_we = !rst;
                    add_val = is_power ? 16'(POWER_SCORE) : 16'(PELLET_SCORE);
                    ate_d   = is_pellet;
                    pow_d   = is_power;
                    if (pel_q != 10'd0) begin
                        pel_d = pel_q - 10'd1;
                        if (pel_q == 10'd1)
                            lc_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        sum     = {1'b0, score_q} + {1'b0, add_val};
        score_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            score_q <= 16'd0;
            pel_q   <= 10'(INIT_PELLETS);
            lc_q    <= 1'b0;
            ate_q   <= 1'b0;
            pow_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            score_q <= score_d;
            pel_q   <= pel_d;
            lc_q    <= lc_d;
            ate_q   <= ate_d;
            pow_q   <= pow_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign bram_addr    = addr_q;
    assign bram_din     = DATA_WIDTH'(TILE_EMPTY);
    assign score        = score_q;
    assign pellets_left = pel_q;
    assign ate_pulse    = ate_q;
    assign power_pulse  = pow_q;
    assign level_clear  = lc_q;

endmodule

// File: tb/tb_pellet_eater.sv
// Scoreboard bench: driver pushes the expected post-request counters, a
// monitor pops them three edges after each accepted request and compares.
module tb_pellet_eater;

    localparam int AW = $clog2(28*31);

    typedef struct {
        logic [15:0] score;
        logic [9:0]  pel;
        logic        lc;
        logic        ate;
        logic        pow;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    tile_x, tile_y;
    logic [AW-1:0] bram_addr;
    logic          bram_we;
    logic [3:0]    bram_din;
    logic [3:0]    bram_dout;
    logic [15:0]   score;
    logic [9:0]    pellets_left;
    logic          ate_pulse, power_pulse, level_clear;

    logic [3:0]    mem [0:28*31-1];
    exp_t          q[$];
    int            errs = 0;
    int            checks = 0;
    int            we_cnt = 0;
    int            exp_we = 0;
    int            m_score, m_pel;
    logic          m_lc;

    pellet_eater dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .tile_x(tile_x), .tile_y(tile_y), .bram_addr(bram_addr),
        .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout),
        .score(score), .pellets_left(pellets_left), .ate_pulse(ate_pulse),
        .power_pulse(power_pulse), .level_clear(level_clear)
    );

    always #5 clk = ~clk;

    // Port-B model: registered read, write-through on we
    always @(posedge clk) begin
        bram_dout <= mem[bram_addr];
        if (bram_we) mem[bram_addr] <= bram_din;
        if (bram_we) we_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one request; optionally preload the tile first. v is the tile code.
    task automatic eat(input int x, input int y, input int v, input bit load);
        exp_t e;
        int   to;
        bit   inr;
        inr = (x < 28) && (y < 31);
        @(negedge clk);
        if (load && inr) mem[y*28 + x] = 4'(v);
        e.ate = 1'b0;
        e.pow = 1'b0;
        if (inr && (v == 2 || v == 3)) begin
            m_score = m_score + ((v == 3) ? 50 : 10);
            if (m_score > 65535) m_score = 65535;
            if (m_pel > 0) begin
                m_pel--;
                if (m_pel == 0) m_lc = 1'b1;
            end
            e.ate = (v == 2);
            e.pow = (v == 3);
            exp_we++;
        end
        e.score = 16'(m_score);
        e.pel   = 10'(m_pel);
        e.lc    = m_lc;
        to = 0;
        while (!req_ready && to < 20) begin
            @(negedge clk);
            to++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 0, 1);
        end else begin
            q.push_back(e);
            req_valid = 1'b1;
            tile_x    = 5'(x);
            tile_y    = 5'(y);
            @(negedge clk);
            req_valid = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    // Monitor: accept edge is edge 1, counters visible after edge 3
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (req_valid && req_ready && !rst && q.size() > 0) begin
                e = q.pop_front();
                @(posedge clk);
                @(posedge clk);
                #1;
                chk("score", int'(score), int'(e.score));
                chk("pellets_left", int'(pellets_left), int'(e.pel));
                chk("level_clear", int'(level_clear), int'(e.lc));
                chk("ate_pulse", int'(ate_pulse), int'(e.ate));
                chk("power_pulse", int'(power_pulse), int'(e.pow));
                @(posedge clk);
                #1;
                chk("pulse_drop", int'({ate_pulse, power_pulse}), 0);
            end
        end
    end

    initial begin
        int to;
        for (int i = 0; i < 28*31; i++) mem[i] = 4'd0;
        mem[31] = 4'd2;
        mem[85] = 4'd3;
        mem[0]  = 4'd1;
        rst = 1'b1; req_valid = 1'b0; tile_x = '0; tile_y = '0;
        m_score = 0; m_pel = 244; m_lc = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_score", int'(score), 0);
        chk("rst_pellets", int'(pellets_left), 244);
        chk("rst_lc", int'(level_clear), 0);
        chk("rst_pulses", int'({ate_pulse, power_pulse}), 0);
        chk("rst_addr", int'(bram_addr), 0);
        chk("rst_we", int'(bram_we), 0);
        rst = 1'b0;

        eat(3, 1, 2, 1'b0);
        chk("addr31_cleared", int'(mem[31]), 0);
        eat(1, 3, 3, 1'b0);
        chk("addr85_cleared", int'(mem[85]), 0);
        eat(0, 0, 1, 1'b0);
        eat(3, 1, 0, 1'b0);
        eat(28, 0, 2, 1'b0);
        eat(0, 31, 2, 1'b0);
        eat(31, 31, 2, 1'b0);
        chk("wall_mem", int'(mem[0]), 1);
        chk("we_count_a", we_cnt, exp_we);

        // Reset lands while the FSM sits in CHK on a pellet tile
        @(negedge clk);
        mem[31] = 4'd2;
        req_valid = 1'b1; tile_x = 5'd3; tile_y = 5'd1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_chk_we", int'(bram_we), 0);
        @(negedge clk);
        chk("rst_chk_mem", int'(mem[31]), 2);
        chk("rst_chk_score", int'(score), 0);
        chk("rst_chk_pel", int'(pellets_left), 244);
        chk("rst_chk_ready", int'(req_ready), 1);
        chk("rst_chk_pulse", int'(ate_pulse), 0);
        rst = 1'b0;
        m_score = 0; m_pel = 244; m_lc = 1'b0;

        // Drain every pellet, then one more to probe underflow
        for (int i = 0; i < 245; i++) eat(3, 1, 2, 1'b1);
        chk("drained_pel", int'(pellets_left), 0);
        chk("drained_lc", int'(level_clear), 1);

        // Climb toward the score ceiling: 2450 + 1261*50 = 65500
        for (int i = 0; i < 1261; i++) eat(1, 3, 3, 1'b1);
        chk("near_top", int'(score), 65500);
        for (int i = 0; i < 5; i++) eat(3, 1, 2, 1'b1);
        chk("sat_score", int'(score), 65535);
        chk("we_count_b", we_cnt, exp_we);

        to = 0;
        while (q.size() > 0 && to < 50) begin
            @(negedge clk);
            to++;
        end
        chk("queue_drained", q.size(), 0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pellet_eater.md
PELLET_EATER -- requirements
Module: pellet_eater

Interface
REQ-001: Parameter MAP_W, default 28, map width in tiles.
REQ-002: Parameter MAP_H, default 31, map height in tiles.
REQ-003: Parameter DATA_WIDTH, default 4, tile code width; matches map BRAM width.
REQ-004: Parameter INIT_PELLETS, default 244, pellet plus power-pellet count loaded at reset.
REQ-005: Derived ADDR_W = $clog2(MAP_W*MAP_H).
REQ-006: clk  in  1  single clock; all state changes on its rising edge.
REQ-007: rst  in  1  reset, synchronous, active-high.
REQ-008: req_valid  in  1  Pacman has entered tile (tile_x, tile_y).
REQ-009: req_ready  out  1  block can accept a request.
REQ-010: tile_x  in  5  tile column; tile_y  in  5  tile row.
REQ-011: bram_addr  out  ADDR_W  map BRAM port-B address.
REQ-012: bram_we  out  1  map BRAM port-B write enable.
REQ-013: bram_din  out  DATA_WIDTH  map BRAM port-B write data.
REQ-014: bram_dout  in  DATA_WIDTH  map BRAM port-B read data; registered, 1-cycle read latency.
REQ-015: score  out  16  accumulated score.
REQ-016: pellets_left  out  10  remaining edible tiles.
REQ-017: ate_pulse  out  1  one-cycle strobe: normal pellet eaten.
REQ-018: power_pulse  out  1  one-cycle strobe: power pellet eaten.
REQ-019: level_clear  out  1  sticky flag: pellets_left reached 0.

Function
REQ-020: FSM states IDLE, RD, CHK; req_ready SHALL be 1 only in IDLE.
REQ-021: IDLE with req_valid: latch addr = tile_y*MAP_W + tile_x into a register driving bram_addr; go RD.
REQ-022: Out-of-range request (tile_x>=MAP_W or tile_y>=MAP_H): accept, no BRAM access, no counter change; stay IDLE.
REQ-023: RD: bram_we=0; unconditionally go CHK; bram_dout is valid during CHK.
REQ-024: CHK with bram_dout==TILE_PELLET: bram_we=1, bram_din=TILE_EMPTY, same bram_addr; score+=10; pellets_left-=1; ate_pulse=1 for the next cycle.
REQ-025: CHK with bram_dout==TILE_POWER: same write; score+=50; pellets_left-=1; power_pulse=1 for the next cycle.
REQ-026: CHK with any other code: bram_we=0, no counter change.
REQ-027: CHK always returns to IDLE; request-to-score-update latency = 3 rising edges; throughput = 1 request per 3 cycles.
REQ-028: bram_we SHALL be asserted only in CHK, combinationally from state and bram_dout.
REQ-029: score SHALL saturate at 16'hFFFF; no wrap-around.
REQ-030: pellets_left SHALL not decrement below 0; on transition to 0, level_clear is set and held until reset.
REQ-031: req_valid outside IDLE is ignored; the requester holds it until req_ready.

Reset
REQ-032: While rst=1: state=IDLE, score=0, pellets_left=INIT_PELLETS, level_clear=0, ate_pulse=0, power_pulse=0, bram_addr=0.
REQ-033: bram_we SHALL be forced 0 combinationally while rst=1, including reset asserted in CHK.
REQ-034: An operation interrupted by reset is discarded: no score, counter, or strobe effect.

Structure
REQ-035: Package pacman_pkg SHALL hold TILE_EMPTY=0, TILE_WALL=1, TILE_PELLET=2, TILE_POWER=3, PELLET_SCORE=10, POWER_SCORE=50, MAP_W, MAP_H, and the FSM state enum.
REQ-036: No sub-module; the block connects directly to port B of dual_port_bram; port A is reserved for the renderer.

Verification
REQ-037: Tile (3,1) holds 2 -> write 0 at addr 31, score 0->10, pellets_left 244->243, ate_pulse 1 cycle, 3 edges after accept.
REQ-038: Tile (1,3) holds 3 -> addr 85 cleared, score +50, power_pulse 1 cycle, ate_pulse stays 0.
REQ-039: Tile (0,0) holds 1, then repeat request to a cleared tile -> bram_we never 1, score/pellets_left unchanged.
REQ-040: INIT_PELLETS=2, eat two pellets -> pellets_left 0, level_clear=1; third eat of a pellet tile does not underflow.
REQ-041: Preload score 16'hFFF8, eat pellet -> score=16'hFFFF.
REQ-042: rst asserted during CHK on a pellet tile -> bram_we=0, tile still 2, score=0, state IDLE next cycle.
